// File: rtl/fht_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fht_sequencer
// Brief    : Loads one frame of ADC samples into a 4-bank FHT RAM, starts the
//            transform, and streams the result back out in natural order.
// Revision : 1.0  initial release
// ============================================================================
module fht_sequencer #(
    parameter int D_BIT     = 22,
    parameter int A_BIT     = 8,
    parameter int ADC_WIDTH = 16,
    parameter int RD_LAT    = 2
) (
    input  logic                        iCLK,
    input  logic                        iRESET,
    input  logic                        iRUN,
    input  logic signed [ADC_WIDTH-1:0] iADC_DATA,
    input  logic                        iADC_VALID,
    output logic                        oADC_READY,
    output logic [3:0]                  oFHT_WE,
    output logic [D_BIT-1:0]            oFHT_DATA,
    output logic [A_BIT-1:0]            oFHT_ADDR_WR,
    output logic                        oFHT_START,
    input  logic                        iFHT_RDY,
    output logic [A_BIT-1:0]            oFHT_ADDR_RD,
    input  logic [D_BIT-1:0]            iFHT_Q_0,
    input  logic [D_BIT-1:0]            iFHT_Q_1,
    input  logic [D_BIT-1:0]            iFHT_Q_2,
    input  logic [D_BIT-1:0]            iFHT_Q_3,
    output logic [D_BIT-1:0]            oRES_DATA,
    output logic                        oRES_VALID,
    output logic                        oBUSY,
    output logic                        oDONE,
    output logic                        oOVF
);

    localparam int c_NB  = A_BIT + 2;
    localparam int c_PAD = D_BIT - ADC_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_READ_ADDR,
        S_READ_LAT,
        S_READ_OUT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_NB-1:0]    r_n;
    logic               r_last;
    logic               r_wait;
    logic [A_BIT-1:0]   r_row;
    logic [1:0]         r_lat;
    logic [1:0]         r_word;
    logic [D_BIT-1:0]   r_buf [4];
    logic [3:0]         r_we;
    logic [D_BIT-1:0]   r_wdata;
    logic [A_BIT-1:0]   r_waddr;
    logic               r_ovf;

    logic               w_ready;
    logic               w_accept;
    logic               w_lat_last;
    logic               w_row_last;
    logic               w_active;

    // r_last holds LOAD one extra cycle so the final registered write lands
    // before the start pulse; the ready line is dropped during that cycle.
    assign w_ready    = (r_state == S_LOAD) && !r_last;
    assign w_accept   = w_ready && iADC_VALID;
    assign w_lat_last = (r_lat == 2'(RD_LAT - 1));
    assign w_row_last = &r_row;
    assign w_active   = r_state inside {S_LOAD, S_START, S_WAIT,
                                        S_READ_ADDR, S_READ_LAT, S_READ_OUT};

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (iRUN) w_state_nxt = S_LOAD;
            S_LOAD:      if (r_last) w_state_nxt = S_START;
            S_START:     w_state_nxt = S_WAIT;
            // The ready flag may still reflect the previous transform right
            // after start, so it is only honoured from the second WAIT cycle.
            S_WAIT:      if (r_wait && iFHT_RDY) w_state_nxt = S_READ_ADDR;
            S_READ_ADDR: w_state_nxt = S_READ_LAT;
            S_READ_LAT:  if (w_lat_last) w_state_nxt = S_READ_OUT;
            S_READ_OUT: begin
                if (r_word == 2'd3) begin
                    w_state_nxt = w_row_last ? S_DONE : S_READ_ADDR;
                end
            end
            S_DONE:      w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            r_n     <= '0;
            r_last  <= 1'b0;
            r_wait  <= 1'b0;
            r_row   <= '0;
            r_lat   <= '0;
            r_word  <= '0;
            r_we    <= '0;
            r_wdata <= '0;
            r_waddr <= '0;
            r_ovf   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            r_we   <= '0;
            r_wait <= (r_state == S_WAIT);

            if (r_state == S_IDLE && iRUN) begin
                r_ovf <= 1'b0;
            end else if (w_active && iADC_VALID && !w_ready) begin
                r_ovf <= 1'b1;
            end

            if (w_accept) begin
                r_we    <= 4'b0001 << r_n[1:0];
                r_wdata <= {iADC_DATA, {c_PAD{1'b0}}};
                r_waddr <= r_n[c_NB-1:2];
                r_n     <= r_n + 1'b1;
                if (&r_n) begin
                    r_last <= 1'b1;
                end
            end else if (r_state == S_LOAD && r_last) begin
                r_last <= 1'b0;
            end

            if (r_state == S_READ_LAT) begin
                r_lat <= w_lat_last ? 2'd0 : r_lat + 2'd1;
                if (w_lat_last) begin
                    r_buf[0] <= iFHT_Q_0;
                    r_buf[1] <= iFHT_Q_1;
                    r_buf[2] <= iFHT_Q_2;
                    r_buf[3] <= iFHT_Q_3;
                end
            end

            // Row counter wraps to zero after the final row.
            if (r_state == S_READ_OUT) begin
                r_word <= r_word + 2'd1;
                if (r_word == 2'd3) begin
                    r_row <= r_row + 1'b1;
                end
            end
        end
    end

    for (genvar i = 0; i < A_BIT; i++) begin : g_bitrev
        assign oFHT_ADDR_RD[i] = r_row[A_BIT-1-i];
    end

    assign oADC_READY   = w_ready;
    assign oFHT_WE      = r_we;
    assign oFHT_DATA    = r_wdata;
    assign oFHT_ADDR_WR = r_waddr;
    assign oFHT_START   = (r_state == S_START);
    assign oRES_VALID   = (r_state == S_READ_OUT);
    assign oRES_DATA    = (r_state == S_READ_OUT) ? r_buf[r_word] : '0;
    assign oBUSY        = (r_state != S_IDLE);
    assign oDONE        = (r_state == S_DONE);
    assign oOVF         = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fht_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fht_sequencer
// Brief    : Random-stimulus scoreboard bench for fht_sequencer with a
//            loop-back FHT RAM model (A_BIT = 3, RD_LAT = 2).
// Revision : 1.0  initial release
// ============================================================================
module tb_fht_sequencer;

    localparam int D_BIT     = 22;
    localparam int A_BIT     = 3;
    localparam int ADC_WIDTH = 16;
    localparam int RD_LAT    = 2;
    localparam int BS        = 8;
    localparam int N         = 32;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        run = 1'b0;
    logic signed [ADC_WIDTH-1:0] adc_data = '0;
    logic                        adc_valid = 1'b0;
    logic                        adc_ready;
    logic [3:0]                  fht_we;
    logic [D_BIT-1:0]            fht_data;
    logic [A_BIT-1:0]            fht_addr_wr;
    logic                        fht_start;
    logic                        fht_rdy = 1'b1;
    logic [A_BIT-1:0]            fht_addr_rd;
    logic [D_BIT-1:0]            q0, q1, q2, q3;
    logic [D_BIT-1:0]            res_data;
    logic                        res_valid;
    logic                        busy;
    logic                        done;
    logic                        ovf;

    fht_sequencer #(
        .D_BIT(D_BIT), .A_BIT(A_BIT), .ADC_WIDTH(ADC_WIDTH), .RD_LAT(RD_LAT)
    ) dut (
        .iCLK(clk), .iRESET(rst), .iRUN(run),
        .iADC_DATA(adc_data), .iADC_VALID(adc_valid), .oADC_READY(adc_ready),
        .oFHT_WE(fht_we), .oFHT_DATA(fht_data), .oFHT_ADDR_WR(fht_addr_wr),
        .oFHT_START(fht_start), .iFHT_RDY(fht_rdy), .oFHT_ADDR_RD(fht_addr_rd),
        .iFHT_Q_0(q0), .iFHT_Q_1(q1), .iFHT_Q_2(q2), .iFHT_Q_3(q3),
        .oRES_DATA(res_data), .oRES_VALID(res_valid), .oBUSY(busy),
        .oDONE(done), .oOVF(ovf)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FHT RAM stand-in: stores what is written, reads back with RD_LAT delay.
    logic [D_BIT-1:0] mem [4][BS];
    logic [A_BIT-1:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (fht_we[b]) mem[b][fht_addr_wr] <= fht_data;
        end
        rd_pipe[0] <= fht_addr_rd;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign q0 = mem[0][rd_pipe[RD_LAT-1]];
    assign q1 = mem[1][rd_pipe[RD_LAT-1]];
    assign q2 = mem[2][rd_pipe[RD_LAT-1]];
    assign q3 = mem[3][rd_pipe[RD_LAT-1]];

    typedef struct packed {
        logic [3:0]       we;
        logic [A_BIT-1:0] addr;
        logic [D_BIT-1:0] data;
    } wr_t;

    wr_t              q_wr[$];
    logic [D_BIT-1:0] q_res[$];
    logic signed [ADC_WIDTH-1:0] samp [N];
    int rev_tbl [BS] = '{0, 4, 2, 6, 1, 5, 3, 7};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor state
    int  we_cnt = 0;
    int  frame_res = 0;
    int  start_cyc = 0;
    int  last_val_cyc = 0;
    int  rdy_rise_cyc = 0;
    bit  lat_chk = 1'b1;

    always @(negedge clk) begin
        if (rst) begin
            we_cnt = 0;
        end else begin
            if (|fht_we) begin
                check("wr_expected", 64'(q_wr.size() != 0), 64'd1);
                if (q_wr.size() != 0) begin
                    wr_t e;
                    e = q_wr.pop_front();
                    check("wr_we_addr_data", 64'({fht_we, fht_addr_wr, fht_data}), 64'(e));
                end
                we_cnt++;
            end
            if (fht_start) begin
                check("start_after_n_writes", 64'(we_cnt), 64'(N));
                check("we_low_at_start", 64'(fht_we), 64'd0);
                start_cyc = cyc;
                we_cnt    = 0;
                frame_res = 0;
            end
            if (res_valid) begin
                if (frame_res == 0) begin
                    if (lat_chk) check("start_to_first_word", 64'(cyc - start_cyc), 64'(4 + RD_LAT));
                    else         check("rdy_to_first_word", 64'(cyc - rdy_rise_cyc), 64'(2 + RD_LAT));
                end
                check("rd_addr_bitrev", 64'(fht_addr_rd), 64'(rev_tbl[(frame_res / 4) % BS]));
                check("res_expected", 64'(q_res.size() != 0), 64'd1);
                if (q_res.size() != 0) check("res_data", 64'(res_data), 64'(q_res.pop_front()));
                frame_res++;
                last_val_cyc = cyc;
            end
            if (done) begin
                check("done_after_last_word", 64'(cyc - last_val_cyc), 64'd1);
                check("words_per_frame", 64'(frame_res), 64'(N));
            end
        end
    end

    function automatic logic [59:0] all_outs();
        return {adc_ready, fht_we, fht_data, fht_addr_wr, fht_start, fht_addr_rd,
                res_data, res_valid, busy, done, ovf};
    endfunction

    task automatic run_pulse();
        @(posedge clk); #1 run = 1'b1;
        @(posedge clk); #1 run = 1'b0;
    endtask

    // kind 0: random with signed extremes up front; kind 1: ramp
    task automatic fill_frame(input int kind);
        for (int i = 0; i < N; i++) begin
            samp[i] = (kind == 1) ? ADC_WIDTH'(i) : ADC_WIDTH'($urandom);
        end
        if (kind == 0) begin
            samp[0] = -16'sd1;
            samp[1] = 16'sh7fff;
            samp[2] = 16'sh8000;
        end
    endtask

    task automatic load_samples(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            int guard;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            adc_valid = 1'b1;
            adc_data  = samp[i];
            q_wr.push_back('{we: 4'(1 << (i % 4)), addr: A_BIT'(i / 4),
                             data: {samp[i], {(D_BIT-ADC_WIDTH){1'b0}}}});
            guard = 0;
            do begin
                @(negedge clk);
                guard++;
            end while (!adc_ready && guard < 20);
            check("ready_in_load", 64'(adc_ready), 64'd1);
            @(posedge clk); #1 adc_valid = 1'b0;
        end
    endtask

    task automatic push_results();
        for (int r = 0; r < BS; r++)
            for (int b = 0; b < 4; b++)
                q_res.push_back({samp[rev_tbl[r] * 4 + b], {(D_BIT-ADC_WIDTH){1'b0}}});
    endtask

    task automatic wait_start();
        bit seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (fht_start) seen = 1'b1;
        end
        check("start_seen", 64'(seen), 64'd1);
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("done_seen", 64'(seen), 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < BS; a++) mem[b][a] = '0;
        for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 check("outputs_in_reset", 64'(all_outs()), 64'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("idle_after_reset", 64'(all_outs()), 64'd0);

        // Frame 1: random data incl. sign extremes; stray iRUN mid-read
        fht_rdy = 1'b1; lat_chk = 1'b1;
        fill_frame(0);
        run_pulse();
        load_samples(N);
        push_results();
        repeat (20) @(posedge clk);
        run_pulse();
        wait_done(400);
        repeat (3) @(posedge clk);
        #1 check("run_ignored_when_busy", 64'(busy), 64'd0);
        check("ovf_clear_f1", 64'(ovf), 64'd0);

        // Frame 2: ready held low 50 cycles, overrun pulse in WAIT
        fht_rdy = 1'b0; lat_chk = 1'b0;
        fill_frame(0);
        run_pulse();
        load_samples(N);
        push_results();
        wait_start();
        @(posedge clk); #1 adc_valid = 1'b1; adc_data = 16'sh1234;
        @(posedge clk); #1 adc_valid = 1'b0;
        @(negedge clk) check("ovf_set_in_wait", 64'(ovf), 64'd1);
        repeat (48) @(posedge clk);
        #1 check("no_read_while_rdy_low", 64'(q_res.size()), 64'(N));
        fht_rdy = 1'b1; rdy_rise_cyc = cyc;
        wait_done(400);
        check("ovf_sticky", 64'(ovf), 64'd1);

        // Frame 3: ramp; iRUN clears overrun flag
        lat_chk = 1'b1;
        fill_frame(1);
        run_pulse();
        check("ovf_cleared_by_run", 64'(ovf), 64'd0);
        load_samples(N);
        push_results();
        wait_done(400);

        // Frame 4: reset mid-load, then a fresh frame from n = 0
        fill_frame(0);
        run_pulse();
        load_samples(20);
        @(posedge clk); #2 rst = 1'b1;
        #1 check("async_reset_outputs", 64'(all_outs()), 64'd0);
        q_wr.delete();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (10) @(posedge clk);
        #1 check("no_resume_after_reset", 64'({busy, fht_we, adc_ready}), 64'd0);
        fill_frame(0);
        run_pulse();
        load_samples(N);
        push_results();
        wait_done(400);

        check("wr_queue_drained", 64'(q_wr.size()), 64'd0);
        check("res_queue_drained", 64'(q_res.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
